// File: rtl/video_system_cpu_oci_dct_packer.sv
// video_system_cpu_oci_dct_packer
// Packs 2-bit CPU trace atoms LSB-first into 30-bit frames and hands them to
// the trace sink over a valid/ready handshake. On test_ending it flushes any
// partial frame and then raises the sticky test_has_ended flag.
//
// Optional build macro: VIDEO_SYSTEM_CPU_OCI_DCT_DROP_EN
//   defined   -> atom_ready is 1 whenever the FSM is in RUN. Atoms that would
//                otherwise stall are discarded and counted in dct_drop_count_o,
//                which saturates at 16'hFFFF.
//   undefined -> atoms are backpressured and there is no drop counter port.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | normal packing; atoms accepted, flush requests honoured
// ST_DRAIN | test ending; no new atoms, partial frame forced out
// ST_ENDED | drain complete; test_has_ended held high until reset

module video_system_cpu_oci_dct_packer #(
    parameter int ATOM_W      = 2,
    parameter int FRAME_ATOMS = 15
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          atom_valid_i,
    input  logic [ATOM_W-1:0]             atom_data_i,
    output logic                          atom_ready_o,
    input  logic                          flush_i,
    input  logic                          test_ending_i,
    output logic [ATOM_W*FRAME_ATOMS-1:0] dct_buffer_o,
    output logic [3:0]                    dct_count_o,
    output logic                          frame_valid_o,
    input  logic                          frame_ready_i,
    output logic                          test_has_ended_o
`ifdef VIDEO_SYSTEM_CPU_OCI_DCT_DROP_EN
    ,
    output logic [15:0]                   dct_drop_count_o
`endif
);

    localparam int         FRAME_W  = ATOM_W * FRAME_ATOMS;
    localparam logic [3:0] FULL_CNT = 4'(FRAME_ATOMS);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ENDED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   acc_q, acc_d;
    logic [3:0]           acc_cnt_q, acc_cnt_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [FRAME_W-1:0]   buf_q, buf_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 fv_q, fv_d;

    logic                 out_free;
    logic                 xfer;
    logic                 take_ok;
    logic                 accept;
    logic [FRAME_W-1:0]   acc_base;
    logic [3:0]           cnt_base;

    // Handshake qualifiers: output slot free, frame transfer, atom acceptance.
    always_comb begin
        out_free = !fv_q || frame_ready_i;
        xfer     = ((acc_cnt_q == FULL_CNT) || (flush_pend_q && (acc_cnt_q != 4'd0))) && out_free;
        // A pending flush with a blocked output would otherwise mix new atoms into the flushed frame.
        take_ok  = (state_q == ST_RUN) && ((acc_cnt_q != FULL_CNT) || out_free)
                   && !(flush_pend_q && !out_free);
        accept   = atom_valid_i && take_ok;
    end

`ifdef VIDEO_SYSTEM_CPU_OCI_DCT_DROP_EN
    logic [15:0] drop_q, drop_d;

    assign atom_ready_o     = (state_q == ST_RUN);
    assign dct_drop_count_o = drop_q;

    // Count offers that arrive in RUN while the packer cannot take them.
    always_comb begin
        drop_d = drop_q;
        if (atom_valid_i && (state_q == ST_RUN) && !take_ok && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end
`else
    assign atom_ready_o = take_ok;
`endif

    // Accumulator, flush flag and output frame next-state.
    always_comb begin
        acc_base     = xfer ? '0 : acc_q;
        cnt_base     = xfer ? 4'd0 : acc_cnt_q;
        acc_d        = acc_base;
        acc_cnt_d    = cnt_base;
        flush_pend_d = xfer ? 1'b0 : flush_pend_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        fv_d         = fv_q;

        if (xfer) begin
            buf_d = acc_q;
            cnt_d = acc_cnt_q;
            fv_d  = 1'b1;
        end else if (fv_q && frame_ready_i) begin
            fv_d = 1'b0;
        end

        // The atom lands in slot 0 when the accumulator is emptied this cycle.
        if (accept) begin
            acc_d     = acc_base | (FRAME_W'(atom_data_i) << (ATOM_W * int'(cnt_base)));
            acc_cnt_d = cnt_base + 4'd1;
        end

        if ((state_q == ST_RUN) && flush_i && (acc_cnt_d != 4'd0)) begin
            flush_pend_d = 1'b1;
        end

        // While draining, whatever is left is always pushed out.
        if (state_d == ST_DRAIN) begin
            flush_pend_d = 1'b1;
        end
    end

    // FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (test_ending_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((acc_cnt_q == 4'd0) && out_free) begin
                    state_d = ST_ENDED;
                end
            end
            ST_ENDED: state_d = ST_ENDED;
            default:  state_d = ST_RUN;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_RUN;
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            buf_q        <= '0;
            cnt_q        <= '0;
            fv_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            fv_q         <= fv_d;
        end
    end

    assign dct_buffer_o     = buf_q;
    assign dct_count_o      = cnt_q;
    assign frame_valid_o    = fv_q;
    assign test_has_ended_o = (state_q == ST_ENDED);

endmodule

// File: tb/tb_video_system_cpu_oci_dct_packer.sv
// Testbench for video_system_cpu_oci_dct_packer: directed scenarios plus a
// randomized phase, all checked against a queue-based reference model.
// Honours VIDEO_SYSTEM_CPU_OCI_DCT_DROP_EN the same way as the design.

module tb_video_system_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        atom_valid = 1'b0;
    logic [1:0]  atom_data = 2'd0;
    logic        atom_ready;
    logic        flush = 1'b0;
    logic        test_ending = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic        test_has_ended;
`ifdef VIDEO_SYSTEM_CPU_OCI_DCT_DROP_EN
    logic [15:0] dct_drop_count;
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    video_system_cpu_oci_dct_packer dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .atom_valid_i     (atom_valid),
        .atom_data_i      (atom_data),
        .atom_ready_o     (atom_ready),
        .flush_i          (flush),
        .test_ending_i    (test_ending),
        .dct_buffer_o     (dct_buffer),
        .dct_count_o      (dct_count),
        .frame_valid_o    (frame_valid),
        .frame_ready_i    (frame_ready),
        .test_has_ended_o (test_has_ended)
`ifdef VIDEO_SYSTEM_CPU_OCI_DCT_DROP_EN
        ,
        .dct_drop_count_o (dct_drop_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the accumulator is just a list of pending atoms.
    int          m_acc[$];
    bit          m_fp, m_fv, m_run = 1'b1, m_drain, m_ended;
    logic [29:0] m_buf;
    int          m_cnt;
    int          m_drops;

    int fv_seen;
    int stall_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_out_free();
        return !m_fv || frame_ready;
    endfunction

    function automatic bit model_can_take();
        bit of;
        of = model_out_free();
        return m_run && ((m_acc.size() < 15) || of) && !(m_fp && !of);
    endfunction

    task automatic model_reset();
        m_acc.delete();
        m_fp = 0; m_fv = 0; m_run = 1; m_drain = 0; m_ended = 0;
        m_buf = '0; m_cnt = 0; m_drops = 0;
    endtask

    task automatic model_step();
        int  n;
        bit  of, send, can, leave_drain;
        longint packed_val;
        if (!reset_n) begin
            model_reset();
            return;
        end
        n    = m_acc.size();
        of   = model_out_free();
        can  = model_can_take();
        send = ((n == 15) || (m_fp && n > 0)) && of;
        leave_drain = m_drain && (n == 0) && of;
        if (send) begin
            packed_val = 0;
            for (int i = 0; i < n; i++) packed_val += longint'(m_acc[i]) * (longint'(1) << (2 * i));
            m_buf = 30'(packed_val);
            m_cnt = n;
            m_fv  = 1;
            m_acc.delete();
            m_fp  = 0;
        end else if (m_fv && frame_ready) begin
            m_fv = 0;
        end
        if (atom_valid && can) m_acc.push_back(int'(atom_data));
        else if (DROP && atom_valid && m_run && m_drops < 65535) m_drops++;
        if (m_run && flush && m_acc.size() > 0) m_fp = 1;
        if (m_run && test_ending) begin
            m_run = 0; m_drain = 1;
        end else if (leave_drain) begin
            m_drain = 0; m_ended = 1;
        end
        if (m_drain) m_fp = 1;
    endtask

    task automatic check_outputs();
        chk("atom_ready", 32'(atom_ready), DROP ? 32'(m_run) : 32'(model_can_take()));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("dct_buffer", 32'(dct_buffer), 32'(m_buf));
        chk("dct_count", 32'(dct_count), 32'(m_cnt));
        chk("test_has_ended", 32'(test_has_ended), 32'(m_ended));
`ifdef VIDEO_SYSTEM_CPU_OCI_DCT_DROP_EN
        chk("dct_drop_count", 32'(dct_drop_count), 32'(m_drops));
`endif
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        if (frame_valid === 1'b1) fv_seen++;
        if (atom_valid && atom_ready !== 1'b1) stall_seen++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        atom_valid = 0; flush = 0; test_ending = 0;
        reset_n = 0;
        cycle();
        reset_n = 1;
    endtask

    task automatic idle(input int n);
        atom_valid = 0; flush = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_frame_valid", 32'(frame_valid), 32'd0);
        chk("reset_buffer", 32'(dct_buffer), 32'd0);
        chk("reset_count", 32'(dct_count), 32'd0);
        chk("reset_ended", 32'(test_has_ended), 32'd0);

        // Basic pack: 0,1,2,3,... into one full frame.
        frame_ready = 1;
        for (int i = 0; i < 15; i++) begin
            atom_valid = 1; atom_data = 2'(i % 4);
            cycle();
        end
        idle(1);
        chk("basic_valid", 32'(frame_valid), 32'd1);
        chk("basic_buffer", 32'(dct_buffer), 32'h24E4E4E4);
        chk("basic_count", 32'(dct_count), 32'd15);
        idle(2);

        // Partial flush of 3,0,2 then a flush with nothing held.
        atom_valid = 1; atom_data = 2'd3; cycle();
        atom_data = 2'd0; cycle();
        atom_data = 2'd2; cycle();
        atom_valid = 0; flush = 1; cycle();
        flush = 0; cycle();
        chk("partial_valid", 32'(frame_valid), 32'd1);
        chk("partial_buffer", 32'(dct_buffer), 32'h023);
        chk("partial_count", 32'(dct_count), 32'd3);
        idle(2);
        flush = 1; cycle();
        flush = 0;
        idle(3);
        chk("empty_flush_valid", 32'(frame_valid), 32'd0);

        // Randomized traffic with random sink stalls and flushes.
        for (int i = 0; i < 300; i++) begin
            atom_valid  = ($urandom_range(0, 9) < 7);
            atom_data   = 2'($urandom);
            frame_ready = 1'($urandom_range(0, 1));
            flush       = ($urandom_range(0, 19) == 0);
            cycle();
        end
        frame_ready = 1;
        idle(4);

        // Backpressure: sink stalled while 35 atoms are offered.
        do_reset();
        frame_ready = 0;
        for (int i = 0; i < 35; i++) begin
            atom_valid = 1; atom_data = 2'($urandom);
            cycle();
        end
`ifdef VIDEO_SYSTEM_CPU_OCI_DCT_DROP_EN
        chk("bp_drop_count", 32'(dct_drop_count), 32'd5);
`else
        chk("bp_ready_low", 32'(atom_ready), 32'd0);
`endif
        chk("bp_held_valid", 32'(frame_valid), 32'd1);
        chk("bp_held_count", 32'(dct_count), 32'd15);
        frame_ready = 1;
        idle(20);

        // Back-to-back: 45 atoms with the sink always ready.
        do_reset();
        fv_seen = 0; stall_seen = 0;
        for (int i = 0; i < 45; i++) begin
            atom_valid = 1; atom_data = 2'($urandom);
            cycle();
        end
        idle(4);
        chk("b2b_frames", 32'(fv_seen), 32'd3);
        chk("b2b_stalls", 32'(stall_seen), 32'd0);

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 7; i++) begin
            atom_valid = 1; atom_data = 2'($urandom);
            cycle();
        end
        do_reset();
        chk("midrst_valid", 32'(frame_valid), 32'd0);
        chk("midrst_buffer", 32'(dct_buffer), 32'd0);
        chk("midrst_ready", 32'(atom_ready), 32'd1);
        atom_valid = 1; atom_data = 2'd1; cycle();
        atom_data = 2'd3; flush = 1; cycle();
        atom_valid = 0; flush = 0; cycle();
        chk("midrst_count", 32'(dct_count), 32'd2);
        chk("midrst_buffer2", 32'(dct_buffer), 32'h00D);
        idle(3);

        // Drain: 5 atoms, test_ending, sink delays acceptance by 4 cycles.
        for (int i = 0; i < 5; i++) begin
            atom_valid = 1; atom_data = 2'($urandom);
            cycle();
        end
        atom_valid = 0; test_ending = 1; frame_ready = 0;
        for (int i = 0; i < 4; i++) cycle();
        chk("drain_valid", 32'(frame_valid), 32'd1);
        chk("drain_count", 32'(dct_count), 32'd5);
        chk("drain_not_ended", 32'(test_has_ended), 32'd0);
        frame_ready = 1;
        cycle();
        chk("drain_ended", 32'(test_has_ended), 32'd1);
        test_ending = 0; atom_valid = 1;
        for (int i = 0; i < 5; i++) cycle();
        chk("ended_sticky", 32'(test_has_ended), 32'd1);
        chk("ended_no_ready", 32'(atom_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
